// File: rtl/alu_result_collector.sv
// alu_result_collector: gathers a burst of ALU results and presents a
// registered summary (sum, count, opcode mask, carry-out flag) through a
// valid/ready handshake. A burst closes when BURST results have been taken
// or when flush arrives with at least one result collected.
module alu_result_collector #(
  parameter int BURST = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_code,
  input  logic [4:0]       in_res,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [3:0]       out_cnt,
  output logic [3:0]       out_mask,
  output logic             out_ovf
);

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_DONE  = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(BURST);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_acc;
  logic [3:0]       r_cnt;
  logic [3:0]       r_mask;
  logic             r_ovf;

  logic             w_accept;
  logic [ACC_W:0]   w_sum;
  logic [3:0]       w_cnt_nxt;
  logic             w_last;
  logic             w_flush_go;

  // The extra top bit of the widened sum is the carry out of the accumulator.
  assign w_accept   = in_valid && r_in_ready;
  assign w_sum      = {1'b0, r_acc} + {{(ACC_W-4){1'b0}}, in_res};
  assign w_cnt_nxt  = r_cnt + 4'd1;
  assign w_last     = w_accept && (w_cnt_nxt == CNT_LAST);
  // An empty flush is dropped so no zero-length summary is ever produced.
  assign w_flush_go = flush && ((r_cnt != 4'd0) || w_accept);

  // Collector FSM: accumulate beats in ACCUM, hold the summary in DONE until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_ACCUM;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mask      <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (w_accept) begin
            r_acc          <= w_sum[ACC_W-1:0];
            r_cnt          <= w_cnt_nxt;
            r_mask[in_code] <= 1'b1;
            r_ovf          <= r_ovf | w_sum[ACC_W];
          end
          if (w_last || w_flush_go) begin
            r_state     <= S_DONE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          // Inputs and flush are ignored here; only the consumer can release us.
          if (out_ready) begin
            r_state     <= S_ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_mask      <= '0;
            r_ovf       <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_ACCUM;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_acc;
  assign out_cnt   = r_cnt;
  assign out_mask  = r_mask;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench for alu_result_collector: one instance with default
// parameters and one with ACC_W=6 for the carry-out case.
module tb_alu_result_collector;

  typedef struct packed {
    logic [15:0] sum;
    logic [3:0]  cnt;
    logic [3:0]  mask;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: defaults
  logic       v0 = 1'b0, f0 = 1'b0, ordy0 = 1'b1;
  logic [1:0] c0 = '0;
  logic [4:0] r0 = '0;
  logic       rdy0, ov0, ovf0;
  logic [7:0] sum0;
  logic [3:0] cnt0, mask0;

  // Instance 1: ACC_W = 6
  logic       v1 = 1'b0, f1 = 1'b0, ordy1 = 1'b1;
  logic [1:0] c1 = '0;
  logic [4:0] r1 = '0;
  logic       rdy1, ov1, ovf1;
  logic [5:0] sum1;
  logic [3:0] cnt1, mask1;

  alu_result_collector u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_code(c0),
    .in_res(r0), .flush(f0), .out_valid(ov0), .out_ready(ordy0),
    .out_sum(sum0), .out_cnt(cnt0), .out_mask(mask0), .out_ovf(ovf0)
  );

  alu_result_collector #(.BURST(4), .ACC_W(6)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_code(c1),
    .in_res(r1), .flush(f1), .out_valid(ov1), .out_ready(ordy1),
    .out_sum(sum1), .out_cnt(cnt1), .out_mask(mask1), .out_ovf(ovf1)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int s, input int c, input logic [3:0] m, input logic o);
    exp_t e;
    e.sum  = 16'(s);
    e.cnt  = 4'(c);
    e.mask = m;
    e.ovf  = o;
    return e;
  endfunction

  // Monitors: compare every summary handshake against the queued expectation.
  always @(negedge clk) begin
    if (!rst && ov0 && ordy0) begin
      if (q0.size() == 0) begin
        chk("u0_unexpected_summary", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("u0_sum",  {24'd0, sum0},  {16'd0, e.sum});
        chk("u0_cnt",  {28'd0, cnt0},  {28'd0, e.cnt});
        chk("u0_mask", {28'd0, mask0}, {28'd0, e.mask});
        chk("u0_ovf",  {31'd0, ovf0},  {31'd0, e.ovf});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov1 && ordy1) begin
      if (q1.size() == 0) begin
        chk("u1_unexpected_summary", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("u1_sum",  {26'd0, sum1},  {16'd0, e.sum});
        chk("u1_cnt",  {28'd0, cnt1},  {28'd0, e.cnt});
        chk("u1_mask", {28'd0, mask1}, {28'd0, e.mask});
        chk("u1_ovf",  {31'd0, ovf1},  {31'd0, e.ovf});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat0(input logic [4:0] res, input logic [1:0] code);
    v0 = 1'b1; r0 = res; c0 = code;
    tick();
    v0 = 1'b0;
  endtask

  task automatic beat1(input logic [4:0] res, input logic [1:0] code);
    v1 = 1'b1; r1 = res; c1 = code;
    tick();
    v1 = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, ov0},   32'd0);
    chk("rst_in_ready",  {31'd0, rdy0},  32'd1);
    chk("rst_sum",       {24'd0, sum0},  32'd0);
    chk("rst_cnt",       {28'd0, cnt0},  32'd0);
    chk("rst_mask",      {28'd0, mask0}, 32'd0);
    chk("rst_ovf",       {31'd0, ovf0},  32'd0);

    // Full burst: 3+5+7+9 = 24, all four opcodes seen
    q0.push_back(mk(24, 4, 4'b1111, 1'b0));
    beat0(5'd3, 2'b00);
    beat0(5'd5, 2'b01);
    beat0(5'd7, 2'b10);
    beat0(5'd9, 2'b11);
    chk("burst_valid_rise", {31'd0, ov0},  32'd1);
    chk("burst_ready_low",  {31'd0, rdy0}, 32'd0);
    tick();
    chk("burst_valid_1cyc", {31'd0, ov0},  32'd0);
    chk("burst_ready_back", {31'd0, rdy0}, 32'd1);

    // Overflow on the 6-bit instance.
    // 31+31 = 62, +31 = 93 carries past 63 (sticky), wraps to 29, +31 = 60.
    q1.push_back(mk(60, 4, 4'b1000, 1'b1));
    for (int i = 0; i < 4; i++) beat1(5'd31, 2'b11);
    tick();
    // 31+31 = 62, +31 = 93 -> 29 with carry, +2 = 31.
    q1.push_back(mk(31, 4, 4'b1000, 1'b1));
    beat1(5'd31, 2'b11);
    beat1(5'd31, 2'b11);
    beat1(5'd31, 2'b11);
    beat1(5'd2,  2'b11);
    chk("ovf_valid", {31'd0, ov1}, 32'd1);
    tick();

    // Flush with a same-cycle beat: 10 + 4 + 1 = 15, codes 11 and 00
    q0.push_back(mk(15, 3, 4'b1001, 1'b0));
    beat0(5'd10, 2'b11);
    beat0(5'd4,  2'b11);
    v0 = 1'b1; r0 = 5'd1; c0 = 2'b00; f0 = 1'b1;
    tick();
    v0 = 1'b0; f0 = 1'b0;
    chk("flush_valid", {31'd0, ov0}, 32'd1);
    tick();
    chk("flush_cleared_cnt", {28'd0, cnt0}, 32'd0);

    // Empty flush produces nothing
    f0 = 1'b1;
    tick();
    f0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("empty_flush_no_valid", {31'd0, ov0},  32'd0);
      chk("empty_flush_ready",    {31'd0, rdy0}, 32'd1);
      tick();
    end

    // Backpressure: 1+2+3+4 = 10, codes 00 and 01; DONE ignores inputs/flush
    ordy0 = 1'b0;
    q0.push_back(mk(10, 4, 4'b0011, 1'b0));
    beat0(5'd1, 2'b00);
    beat0(5'd2, 2'b00);
    beat0(5'd3, 2'b01);
    beat0(5'd4, 2'b00);
    v0 = 1'b1; r0 = 5'd17; c0 = 2'b10; f0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",    {31'd0, ov0},   32'd1);
      chk("bp_in_ready", {31'd0, rdy0},  32'd0);
      chk("bp_sum",      {24'd0, sum0},  32'd10);
      chk("bp_cnt",      {28'd0, cnt0},  32'd4);
      chk("bp_mask",     {28'd0, mask0}, 32'h3);
      tick();
    end
    v0 = 1'b0; f0 = 1'b0;
    ordy0 = 1'b1;
    tick();
    chk("bp_release_ready", {31'd0, rdy0},  32'd1);
    chk("bp_release_valid", {31'd0, ov0},   32'd0);
    chk("bp_cleared_sum",   {24'd0, sum0},  32'd0);
    chk("bp_cleared_cnt",   {28'd0, cnt0},  32'd0);
    chk("bp_cleared_mask",  {28'd0, mask0}, 32'd0);

    // Reset mid-burst: partial burst discarded, next burst of four 1s
    beat0(5'd5, 2'b00);
    beat0(5'd6, 2'b01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", {31'd0, ov0},   32'd0);
    chk("midrst_ready", {31'd0, rdy0},  32'd1);
    chk("midrst_cnt",   {28'd0, cnt0},  32'd0);
    chk("midrst_sum",   {24'd0, sum0},  32'd0);
    chk("midrst_mask",  {28'd0, mask0}, 32'd0);
    q0.push_back(mk(4, 4, 4'b0001, 1'b0));
    for (int i = 0; i < 4; i++) beat0(5'd1, 2'b00);
    chk("midrst_valid_after", {31'd0, ov0}, 32'd1);
    tick(); tick();

    // Every queued summary must have been seen
    chk("u0_queue_drained", q0.size(), 32'd0);
    chk("u1_queue_drained", q1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
